// File: rtl/dram_fill_responder_pkg.sv
// Shared definitions for the DRAM fill responder slice.
// Holds the DRAM model defaults, the fill FSM state encoding and a small width helper.
// No ports.
package dram_fill_responder_pkg;

   // DRAM model defaults, shared by every user of the responder.
   localparam int unsigned DRAM_LATENCY   = 8;
   localparam int unsigned DRAM_ID_BITS   = 2;
   localparam int unsigned DRAM_MEM_BEATS = 4096;

   typedef logic [1:0] fill_state_t;

   localparam fill_state_t StIdle = 2'd0;
   localparam fill_state_t StWait = 2'd1;
   localparam fill_state_t StSend = 2'd2;

   // Clamp a computed width to at least one bit.
   function automatic int unsigned max1(input int unsigned v);
      return (v < 1) ? 1 : v;
   endfunction

endpackage

// File: rtl/dram_req_fifo.sv
// Parametric synchronous FIFO used as the fill request queue.
// Ports:
//   clk, rst_aH     clock, synchronous active-high reset (clears pointers and count)
//   push, pop       enqueue din / dequeue head; caller must not push when full or pop when empty
//   din             entry to enqueue
//   head            oldest entry (valid when !empty)
//   full, empty     derived from the registered count only
module dram_req_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_aH,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] storage [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;

   // Explicit wrap keeps non-power-of-two depths safe.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
   endfunction

   always_comb begin
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_aH) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         storage[wr_ptr_q] <= din;
      end
   end

   assign head  = storage[rd_ptr_q];
   assign full  = (count_q == CntW'(DEPTH));
   assign empty = (count_q == '0);

endmodule

// File: rtl/dram_fill_responder.sv
// Memory-side responder for I-cache block fills (behavioural DRAM stand-in).
// Queues block-read requests, waits a fixed latency, then streams the block as beats.
// Ports:
//   clk, rst_aH            clock, synchronous active-high reset
//   req_valid/req_ready    request handshake; req_ready = queue not full
//   req_addr, req_id       byte address (offset bits ignored), requester tag
//   resp_valid/resp_ready  beat handshake
//   resp_data, resp_id     beat payload, tag of the block being served
//   resp_beat, resp_last   beat index within the block, final-beat flag
module dram_fill_responder
   import dram_fill_responder_pkg::*;
#(
   parameter int unsigned BLOCK_SIZE_BITS = 64,
   parameter int unsigned BEAT_BITS       = 64,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned ID_BITS         = DRAM_ID_BITS,
   parameter int unsigned MEM_BEATS       = DRAM_MEM_BEATS,
   parameter int unsigned LATENCY         = DRAM_LATENCY,
   parameter int unsigned REQ_Q_DEPTH     = 2,
   parameter string       MEM_INIT_FILE   = ""
) (
   input  logic                  clk,
   input  logic                  rst_aH,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [ID_BITS-1:0]    req_id,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [BEAT_BITS-1:0]  resp_data,
   output logic [ID_BITS-1:0]    resp_id,
   output logic [max1($clog2(BLOCK_SIZE_BITS/BEAT_BITS))-1:0] resp_beat,
   output logic                  resp_last
);

   localparam int unsigned BEATS   = BLOCK_SIZE_BITS / BEAT_BITS;
   localparam int unsigned BeatW   = max1($clog2(BEATS));
   localparam int unsigned MemIdxW = $clog2(MEM_BEATS);
   localparam int unsigned OffBits = $clog2(BLOCK_SIZE_BITS / 8);
   localparam int unsigned LatW    = max1($clog2(LATENCY));
   localparam int unsigned EntryW  = MemIdxW + ID_BITS;

   // Behavioural backing store; read-only through the ports, not reset.
   logic [BEAT_BITS-1:0] mem [MEM_BEATS];

   initial begin
      for (int i = 0; i < int'(MEM_BEATS); i++) begin
         mem[i] = '0;
      end
   end

   // Request queue
   logic [ADDR_WIDTH-1:0] req_blk;
   logic [MemIdxW-1:0]    req_base;
   logic [EntryW-1:0]     q_head;
   logic                  q_full, q_empty, q_push, q_pop;

   // Truncation to MemIdxW bits gives the silent wrap past the end of the store.
   assign req_blk  = req_addr >> OffBits;
   assign req_base = MemIdxW'(req_blk * ADDR_WIDTH'(BEATS));

   assign req_ready = !q_full;
   assign q_push    = req_valid && req_ready;

   dram_req_fifo #(
      .WIDTH (EntryW),
      .DEPTH (REQ_Q_DEPTH)
   ) u_req_fifo (
      .clk    (clk),
      .rst_aH (rst_aH),
      .push   (q_push),
      .pop    (q_pop),
      .din    ({req_id, req_base}),
      .head   (q_head),
      .full   (q_full),
      .empty  (q_empty)
   );

   // Fill FSM
   fill_state_t        state_q, state_d;
   logic [LatW-1:0]    lat_cnt_q, lat_cnt_d;
   logic [BeatW-1:0]   beat_q, beat_d;
   logic [MemIdxW-1:0] cur_base_q, cur_base_d;
   logic [ID_BITS-1:0] cur_id_q, cur_id_d;
   logic               beat_is_last;

   assign beat_is_last = (beat_q == BeatW'(BEATS - 1));

   always_comb begin
      state_d    = state_q;
      lat_cnt_d  = lat_cnt_q;
      beat_d     = beat_q;
      cur_base_d = cur_base_q;
      cur_id_d   = cur_id_q;
      q_pop      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!q_empty) begin
               q_pop      = 1'b1;
               cur_base_d = q_head[MemIdxW-1:0];
               cur_id_d   = q_head[EntryW-1:MemIdxW];
               lat_cnt_d  = LatW'(LATENCY - 1);
               state_d    = StWait;
            end
         end
         StWait: begin
            if (lat_cnt_q == '0) begin
               beat_d  = '0;
               state_d = StSend;
            end else begin
               lat_cnt_d = lat_cnt_q - LatW'(1);
            end
         end
         StSend: begin
            if (resp_ready) begin
               if (beat_is_last) begin
                  beat_d  = '0;
                  state_d = StIdle;
               end else begin
                  beat_d = beat_q + BeatW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_aH) begin
         state_q    <= StIdle;
         lat_cnt_q  <= '0;
         beat_q     <= '0;
         cur_base_q <= '0;
         cur_id_q   <= '0;
      end else begin
         state_q    <= state_d;
         lat_cnt_q  <= lat_cnt_d;
         beat_q     <= beat_d;
         cur_base_q <= cur_base_d;
         cur_id_q   <= cur_id_d;
      end
   end

   // Response outputs depend only on registered state, so they hold under backpressure.
   logic [MemIdxW-1:0] rd_idx;

   assign rd_idx     = cur_base_q + MemIdxW'(beat_q);
   assign resp_valid = (state_q == StSend);
   assign resp_data  = resp_valid ? mem[rd_idx] : '0;
   assign resp_id    = cur_id_q;
   assign resp_beat  = beat_q;
   assign resp_last  = resp_valid && beat_is_last;

endmodule

// File: tb/tb_dram_fill_responder.sv
// Self-checking bench: dut1 uses default parameters (one beat per block),
// dut4 uses 256-bit blocks (four 64-bit beats).
module tb_dram_fill_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic        req_valid1, req_ready1, resp_valid1, resp_ready1, resp_last1;
   logic [31:0] req_addr1;
   logic [1:0]  req_id1, resp_id1;
   logic [63:0] resp_data1;
   logic [0:0]  resp_beat1;

   logic        req_valid4, req_ready4, resp_valid4, resp_ready4, resp_last4;
   logic [31:0] req_addr4;
   logic [1:0]  req_id4, resp_id4;
   logic [63:0] resp_data4;
   logic [1:0]  resp_beat4;

   dram_fill_responder dut1 (
      .clk        (clk),
      .rst_aH     (rst),
      .req_valid  (req_valid1),
      .req_ready  (req_ready1),
      .req_addr   (req_addr1),
      .req_id     (req_id1),
      .resp_valid (resp_valid1),
      .resp_ready (resp_ready1),
      .resp_data  (resp_data1),
      .resp_id    (resp_id1),
      .resp_beat  (resp_beat1),
      .resp_last  (resp_last1)
   );

   dram_fill_responder #(
      .BLOCK_SIZE_BITS (256),
      .BEAT_BITS       (64)
   ) dut4 (
      .clk        (clk),
      .rst_aH     (rst),
      .req_valid  (req_valid4),
      .req_ready  (req_ready4),
      .req_addr   (req_addr4),
      .req_id     (req_id4),
      .resp_valid (resp_valid4),
      .resp_ready (resp_ready4),
      .resp_data  (resp_data4),
      .resp_id    (resp_id4),
      .resp_beat  (resp_beat4),
      .resp_last  (resp_last4)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [63:0] mm [4096];  // expected contents of dut4's store

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  id;
      int          idx;
      logic [63:0] data;
   } vec_t;

   typedef struct {
      logic [1:0] id;
      int         base;
   } exp_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Single-beat fill on dut1 with latency measurement.
   task automatic fill1(input string tag, input vec_t v);
      int lat;
      dut1.mem[v.idx] = v.data;
      req_valid1  = 1'b1;
      req_addr1   = v.addr;
      req_id1     = v.id;
      resp_ready1 = 1'b1;
      check({tag, " req_ready"}, 64'(req_ready1), 64'd1);
      @(negedge clk);
      req_valid1 = 1'b0;
      lat = 1;
      while (!resp_valid1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'd10);
      check({tag, " data"}, resp_data1, v.data);
      check({tag, " ctl"}, 64'({resp_valid1, resp_id1, resp_beat1, resp_last1}),
            64'({1'b1, v.id, 1'b0, 1'b1}));
      @(negedge clk);
      check({tag, " done"}, 64'(resp_valid1), 64'd0);
   endtask

   // Wait (bounded) for a dut4 block and check all four beats with ready held high.
   task automatic expect_block(input string tag, input logic [1:0] id, input int base,
                               output int waited);
      resp_ready4 = 1'b1;
      waited = 0;
      while (!resp_valid4 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      check({tag, " valid"}, 64'(resp_valid4), 64'd1);
      if (!resp_valid4) return;
      for (int b = 0; b < 4; b++) begin
         check($sformatf("%s b%0d data", tag, b), resp_data4, mm[(base + b) % 4096]);
         check($sformatf("%s b%0d ctl", tag, b),
               64'({resp_valid4, resp_id4, resp_beat4, resp_last4}),
               64'({1'b1, id, 2'(b), b == 3}));
         @(negedge clk);
      end
   endtask

   vec_t vecs [4];

   initial begin
      int   w;
      int   stale;
      exp_t q [$];
      int   m_beat;
      bit   req_fire, prev_stall;
      int   blocks;

      vecs[0] = '{addr: 32'h0000_0028, id: 2'd1, idx: 5,    data: 64'hDEADBEEF_0000_0005};
      vecs[1] = '{addr: 32'h0000_8008, id: 2'd2, idx: 1,    data: 64'h1111_2222_3333_0001};
      vecs[2] = '{addr: 32'h0000_003C, id: 2'd3, idx: 7,    data: 64'hABCD_0000_0000_0007};
      vecs[3] = '{addr: 32'hFFFF_FFF8, id: 2'd0, idx: 4095, data: 64'hFEED_FACE_0000_0FFF};

      rst = 1'b1;
      req_valid1 = 1'b0; req_addr1 = '0; req_id1 = '0; resp_ready1 = 1'b0;
      req_valid4 = 1'b0; req_addr4 = '0; req_id4 = '0; resp_ready4 = 1'b0;

      repeat (3) @(negedge clk);
      for (int i = 0; i < 4096; i++) begin
         dut1.mem[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
         mm[i] = {$urandom, $urandom};
         dut4.mem[i] = mm[i];
      end
      rst = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst1 req_ready", 64'(req_ready1), 64'd1);
      check("rst1 resp_valid", 64'(resp_valid1), 64'd0);
      check("rst1 resp_data", resp_data1, 64'd0);
      check("rst1 id/beat/last", 64'({resp_id1, resp_beat1, resp_last1}), 64'd0);
      check("rst4 req_ready", 64'(req_ready4), 64'd1);
      check("rst4 resp_valid", 64'(resp_valid4), 64'd0);
      check("rst4 resp_data", resp_data4, 64'd0);
      check("rst4 id/beat/last", 64'({resp_id4, resp_beat4, resp_last4}), 64'd0);

      // Table-driven single-beat fills (includes offset-ignore and wrap cases)
      for (int i = 0; i < 4; i++) begin
         fill1($sformatf("vec%0d", i), vecs[i]);
      end

      // Multi-beat block at 0x40 -> beats from mem[8..11]
      req_valid4 = 1'b1; req_addr4 = 32'h40; req_id4 = 2'd2;
      check("mb req_ready", 64'(req_ready4), 64'd1);
      @(negedge clk);
      req_valid4 = 1'b0;
      expect_block("mb", 2'd2, 8, w);
      check("mb latency", 64'(w + 1), 64'd10);
      check("mb idle after", 64'(resp_valid4), 64'd0);

      // Backpressure during beat 1 of a block at 0x80 (base 16)
      req_valid4 = 1'b1; req_addr4 = 32'h80; req_id4 = 2'd3; resp_ready4 = 1'b1;
      @(negedge clk);
      req_valid4 = 1'b0;
      w = 0;
      while (!resp_valid4 && w < 40) begin
         @(negedge clk);
         w++;
      end
      check("bp b0 data", resp_data4, mm[16]);
      @(negedge clk);
      check("bp b1 data", resp_data4, mm[17]);
      resp_ready4 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("bp hold%0d data", k), resp_data4, mm[17]);
         check($sformatf("bp hold%0d ctl", k),
               64'({resp_valid4, resp_id4, resp_beat4, resp_last4}), 64'({1'b1, 2'd3, 2'd1, 1'b0}));
      end
      resp_ready4 = 1'b1;
      @(negedge clk);
      check("bp b2 data", resp_data4, mm[18]);
      check("bp b2 beat", 64'({resp_valid4, resp_beat4}), 64'({1'b1, 2'd2}));
      @(negedge clk);
      check("bp b3 data", resp_data4, mm[19]);
      check("bp b3 last", 64'({resp_beat4, resp_last4}), 64'({2'd3, 1'b1}));
      @(negedge clk);
      check("bp idle after", 64'(resp_valid4), 64'd0);

      // Queue full: three back-to-back requests
      for (int k = 0; k < 3; k++) begin
         req_valid4 = 1'b1; req_addr4 = 32'h100 + 32'(k) * 32'h20; req_id4 = 2'(k);
         check($sformatf("qf push%0d ready", k), 64'(req_ready4), 64'd1);
         @(negedge clk);
      end
      req_valid4 = 1'b0;
      check("qf ready low", 64'(req_ready4), 64'd0);
      for (int k = 0; k < 3; k++) begin
         expect_block($sformatf("qf blk%0d", k), 2'(k), 32 + 4 * k, w);
      end
      check("qf ready back", 64'(req_ready4), 64'd1);

      // Reset during beat 1 of a block at 0x200 (base 64)
      req_valid4 = 1'b1; req_addr4 = 32'h200; req_id4 = 2'd1; resp_ready4 = 1'b1;
      @(negedge clk);
      req_valid4 = 1'b0;
      w = 0;
      while (!resp_valid4 && w < 40) begin
         @(negedge clk);
         w++;
      end
      @(negedge clk);
      check("rs beat1", 64'({resp_valid4, resp_beat4}), 64'({1'b1, 2'd1}));
      rst = 1'b1;
      resp_ready4 = 1'b0;
      @(negedge clk);
      check("rs valid low", 64'(resp_valid4), 64'd0);
      check("rs req_ready", 64'(req_ready4), 64'd1);
      check("rs outputs", 64'({resp_data4, resp_beat4, resp_last4} != '0), 64'd0);
      rst = 1'b0;
      resp_ready4 = 1'b1;
      stale = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (resp_valid4) stale++;
      end
      check("rs no stale beats", 64'(stale), 64'd0);
      req_valid4 = 1'b1; req_addr4 = 32'h220; req_id4 = 2'd2;
      check("rs new req_ready", 64'(req_ready4), 64'd1);
      @(negedge clk);
      req_valid4 = 1'b0;
      expect_block("rs new", 2'd2, 68, w);
      check("rs new latency", 64'(w + 1), 64'd10);

      // Randomized traffic against a queue-based reference model
      m_beat = 0; req_fire = 1'b0; prev_stall = 1'b0; blocks = 0;
      for (int cyc = 0; cyc < 3400; cyc++) begin
         @(negedge clk);
         if (req_fire) req_valid4 = 1'b0;
         if (prev_stall) check($sformatf("rnd hold c%0d", cyc), 64'(resp_valid4), 64'd1);
         if (resp_valid4) begin
            if (q.size() == 0) begin
               check($sformatf("rnd spurious c%0d", cyc), 64'(resp_valid4), 64'd0);
            end else begin
               check($sformatf("rnd data c%0d", cyc), resp_data4,
                     mm[(q[0].base + m_beat) % 4096]);
               check($sformatf("rnd ctl c%0d", cyc), 64'({resp_id4, resp_beat4, resp_last4}),
                     64'({q[0].id, 2'(m_beat), m_beat == 3}));
            end
         end
         if (!req_valid4 && cyc < 3000 && $urandom_range(0, 2) == 0) begin
            req_valid4 = 1'b1;
            req_addr4  = $urandom;
            req_id4    = 2'($urandom);
         end
         resp_ready4 = (cyc >= 3000) || ($urandom_range(0, 9) < 7);
         req_fire = req_valid4 && req_ready4;
         if (req_fire) q.push_back('{id: req_id4, base: int'(((req_addr4 >> 5) * 4) % 4096)});
         if (resp_valid4 && resp_ready4 && q.size() != 0) begin
            m_beat++;
            if (m_beat == 4) begin
               m_beat = 0;
               blocks++;
               void'(q.pop_front());
            end
         end
         prev_stall = resp_valid4 && !resp_ready4;
      end
      check("rnd drained", 64'(q.size()), 64'd0);
      check("rnd pending req", 64'(req_valid4 && !req_fire), 64'd0);
      check("rnd enough blocks", 64'(blocks > 20), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
